synth_voice_mixer: RTL and testbench

Upstream stage of the audio CODEC interface. It produces the synthesizer samples wsaudio_outL/wsaudio_outR that the interface adds to the CODEC path. Once per LR frame, while AUD_DACLRCK is high, it sequentially reads NVOICES stereo voice samples from the synth voice RAM, sums the active voices, applies a master volume, limits the result to 16 bits, and presents it with a one-cycle valid strobe. AUD_DACLRCK low holds the block in reset, so each frame restarts from a clean state.

---
 rtl/synth_mixer_pkg.sv | 13 +
 rtl/mixer_limit.sv | 17 +
 rtl/synth_voice_mixer.sv | 101 ++++++++++
 tb/tb_synth_voice_mixer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/synth_mixer_pkg.sv
// synth_mixer_pkg: shared FSM states, gain/sample constants and width helpers for the voice mixer.
package synth_mixer_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SCALE, OUT, DONE} state_t;
    localparam int VOL_UNITY  = 128;
    localparam int VOL_SHIFT  = 7;
    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;
    localparam int SAMPLE_W   = 16;
    localparam int VOL_GUARD  = 9;
    function automatic int acc_width(input int vidx_w);
        return SAMPLE_W + vidx_w + 1;
    endfunction
endpackage

// File: rtl/mixer_limit.sv
// mixer_limit: wide signed value to 16-bit sample; saturates when SYNTH_MIXER_SAT_EN is defined,
// otherwise wraps to the low 16 bits.
module mixer_limit import synth_mixer_pkg::*; #(
    parameter int IN_W = 30
) (
    input  logic signed [IN_W-1:0] i_x,
    output logic signed [15:0]     o_y
);
`ifdef SYNTH_MIXER_SAT_EN
    always_comb o_y = (i_x > IN_W'(SAMPLE_MAX)) ? 16'(SAMPLE_MAX) :
                      (i_x < IN_W'(SAMPLE_MIN)) ? 16'(SAMPLE_MIN) : i_x[15:0];
`else
    logic w_unused;
    assign w_unused = ^i_x[IN_W-1:16];
    assign o_y = i_x[15:0];
`endif
endmodule

// File: rtl/synth_voice_mixer.sv
// synth_voice_mixer: per-LR-frame sum of NVOICES voice samples, master volume, 16-bit limit.
// SYNTH_MIXER_SAT_EN selects saturating (defined) or wrapping (undefined) output limiting.
module synth_voice_mixer import synth_mixer_pkg::*; #(
    parameter int NVOICES = 16,
    parameter int VIDX_W  = 4
) (
    input  logic               iCLK,
    input  logic               AUD_DACLRCK,
    input  logic [7:0]         i_master_vol,
    output logic               o_voice_rd,
    output logic [VIDX_W-1:0]  o_voice_idx,
    input  logic signed [15:0] i_voice_L,
    input  logic signed [15:0] i_voice_R,
    input  logic               i_voice_active,
    output logic signed [15:0] wsaudio_outL,
    output logic signed [15:0] wsaudio_outR,
    output logic               o_valid,
    output logic               o_busy,
    output logic [VIDX_W:0]    o_active_count
);
    localparam int ACC_W  = acc_width(VIDX_W);
    localparam int PROD_W = ACC_W + VOL_GUARD;

    logic [1:0]               r_sync;
    logic                     w_rst_n;
    state_t                   r_state;
    logic                     r_rd_d;
    logic signed [ACC_W-1:0]  r_acc_L, r_acc_R;
    logic [VIDX_W:0]          r_cnt;
    logic signed [8:0]        w_vol;
    logic signed [PROD_W-1:0] w_prod_L, w_prod_R, w_shr_L, w_shr_R;
    logic signed [15:0]       w_lim_L, w_lim_R;

    // Assert asynchronously with LRCK, release two iCLK edges later.
    always_ff @(posedge iCLK or negedge AUD_DACLRCK)
        if (!AUD_DACLRCK) r_sync <= '0;
        else              r_sync <= {r_sync[0], 1'b1};
    assign w_rst_n = r_sync[1];

    assign w_vol    = {1'b0, i_master_vol};
    assign w_prod_L = PROD_W'(r_acc_L) * PROD_W'(w_vol);
    assign w_prod_R = PROD_W'(r_acc_R) * PROD_W'(w_vol);
    assign w_shr_L  = w_prod_L >>> VOL_SHIFT;
    assign w_shr_R  = w_prod_R >>> VOL_SHIFT;

    mixer_limit #(.IN_W(PROD_W)) u_lim_L (.i_x(w_shr_L), .o_y(w_lim_L));
    mixer_limit #(.IN_W(PROD_W)) u_lim_R (.i_x(w_shr_R), .o_y(w_lim_R));

    always_ff @(posedge iCLK or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state        <= IDLE;
            r_rd_d         <= 1'b0;
            r_acc_L        <= '0;
            r_acc_R        <= '0;
            r_cnt          <= '0;
            o_voice_rd     <= 1'b0;
            o_voice_idx    <= '0;
            wsaudio_outL   <= '0;
            wsaudio_outR   <= '0;
            o_valid        <= 1'b0;
            o_busy         <= 1'b0;
            o_active_count <= '0;
        end else begin
            r_rd_d  <= o_voice_rd;
            o_valid <= 1'b0;
            // Read data lags the strobe by one cycle; DRAIN catches the last one.
            if (r_rd_d && i_voice_active) begin
                r_acc_L <= r_acc_L + ACC_W'(i_voice_L);
                r_acc_R <= r_acc_R + ACC_W'(i_voice_R);
                r_cnt   <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_state     <= FETCH;
                    o_voice_rd  <= 1'b1;
                    o_voice_idx <= '0;
                    o_busy      <= 1'b1;
                end
                FETCH:
                    if (o_voice_idx == VIDX_W'(NVOICES - 1)) begin
                        r_state    <= DRAIN;
                        o_voice_rd <= 1'b0;
                    end else
                        o_voice_idx <= o_voice_idx + 1'b1;
                DRAIN: r_state <= SCALE;
                SCALE: begin
                    r_state        <= OUT;
                    wsaudio_outL   <= w_lim_L;
                    wsaudio_outR   <= w_lim_R;
                    o_valid        <= 1'b1;
                    o_active_count <= r_cnt;
                end
                OUT: begin
                    r_state <= DONE;
                    o_busy  <= 1'b0;
                end
                DONE: r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_synth_voice_mixer.sv
// tb_synth_voice_mixer: directed frames against hand-computed mixes, reset hold and mid-frame abort.
module tb_synth_voice_mixer;
    logic               iCLK = 1'b0;
    logic               AUD_DACLRCK = 1'b0;
    logic [7:0]         i_master_vol = 8'd128;
    logic               o_voice_rd;
    logic [3:0]         o_voice_idx;
    logic signed [15:0] i_voice_L = '0;
    logic signed [15:0] i_voice_R = '0;
    logic               i_voice_active = 1'b0;
    logic signed [15:0] wsaudio_outL, wsaudio_outR;
    logic               o_valid, o_busy;
    logic [4:0]         o_active_count;

    int n_checks = 0;
    int n_errors = 0;
    int vl [16];
    int vr [16];
    bit va [16];

    always #10 iCLK = ~iCLK;

    synth_voice_mixer #(.NVOICES(16), .VIDX_W(4)) dut (
        .iCLK(iCLK), .AUD_DACLRCK(AUD_DACLRCK), .i_master_vol(i_master_vol),
        .o_voice_rd(o_voice_rd), .o_voice_idx(o_voice_idx),
        .i_voice_L(i_voice_L), .i_voice_R(i_voice_R), .i_voice_active(i_voice_active),
        .wsaudio_outL(wsaudio_outL), .wsaudio_outR(wsaudio_outR),
        .o_valid(o_valid), .o_busy(o_busy), .o_active_count(o_active_count)
    );

    // Voice RAM responder: one-cycle read latency.
    always @(posedge iCLK) begin
        i_voice_active <= o_voice_rd ? va[o_voice_idx] : 1'b0;
        i_voice_L      <= 16'(vl[o_voice_idx]);
        i_voice_R      <= 16'(vr[o_voice_idx]);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int n_act, input int l0, input int r0, input int l1, input int r1);
        for (int i = 0; i < 16; i++) begin
            va[i] = (i < n_act);
            vl[i] = (i >= n_act) ? 12345 : (i == 1) ? l1 : l0;
            vr[i] = (i >= n_act) ? -777  : (i == 1) ? r1 : r0;
        end
    endtask

    task automatic run_frame(input string tag, input int exp_l, input int exp_r, input int exp_cnt);
        int vcyc = -1;
        int nval = 0;
        int nrd  = 0;
        AUD_DACLRCK = 1'b1;
        repeat (2) @(posedge iCLK);
        for (int n = 0; n < 25; n++) begin
            @(posedge iCLK);
            @(negedge iCLK);
            if (o_voice_rd) nrd++;
            if (n == 0) check({tag, "_busy_fetch"}, o_busy, 1);
            if (o_valid) begin
                nval++;
                vcyc = n + 1;
            end
        end
        check({tag, "_valid_cycle"}, vcyc, 19);
        check({tag, "_valid_pulses"}, nval, 1);
        check({tag, "_reads"}, nrd, 16);
        check({tag, "_L"}, int'(wsaudio_outL), exp_l);
        check({tag, "_R"}, int'(wsaudio_outR), exp_r);
        check({tag, "_count"}, int'(o_active_count), exp_cnt);
        check({tag, "_busy_done"}, o_busy, 0);
        AUD_DACLRCK = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    initial begin
        int nval;
        repeat (20) @(negedge iCLK);
        check("rst_L", int'(wsaudio_outL), 0);
        check("rst_R", int'(wsaudio_outR), 0);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rd", o_voice_rd, 0);
        check("rst_count", int'(o_active_count), 0);

        load(2, 1000, 500, -300, 500);
        i_master_vol = 8'd128;
        run_frame("unity", 700, 1000, 2);
        i_master_vol = 8'd64;
        run_frame("half", 350, 500, 2);
        i_master_vol = 8'd255;
        run_frame("vol255", 1394, 1992, 2);
        i_master_vol = 8'd0;
        run_frame("vol0", 0, 0, 2);
        load(0, 0, 0, 0, 0);
        i_master_vol = 8'd128;
        run_frame("none", 0, 0, 0);
        load(16, 30000, 100, 30000, 100);
`ifdef SYNTH_MIXER_SAT_EN
        run_frame("pos_big", 32767, 1600, 16);
`else
        run_frame("pos_big", 21248, 1600, 16);
`endif
        load(16, -30000, -100, -30000, -100);
`ifdef SYNTH_MIXER_SAT_EN
        run_frame("neg_big", -32768, -1600, 16);
`else
        run_frame("neg_big", -21248, -1600, 16);
`endif

        load(2, 1000, 500, -300, 500);
        AUD_DACLRCK = 1'b1;
        repeat (2) @(posedge iCLK);
        repeat (7) @(posedge iCLK);
        #2 AUD_DACLRCK = 1'b0;
        #1;
        check("abort_L", int'(wsaudio_outL), 0);
        check("abort_R", int'(wsaudio_outR), 0);
        check("abort_busy", o_busy, 0);
        check("abort_rd", o_voice_rd, 0);
        nval = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge iCLK);
            if (o_valid) nval++;
        end
        check("abort_no_valid", nval, 0);
        run_frame("after_abort", 700, 1000, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
